// File: rtl/bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl
//   Sequencer for multi-byte packed-BCD addition. A request (a, b, cin) is
//   captured in IDLE, then added one byte (two digits) per cycle, least
//   significant byte first, through a single 2-digit BCD adder stage with a
//   registered decimal carry. The result is offered on a valid/ready port.
//
//   Optional feature macro: BCD_SUB_EN
//     defined   -> port i_sub exists; i_sub=1 computes a-b in ten's complement
//                  (b nine's-complemented per digit, carry-in forced to 1).
//     undefined -> addition only, no i_sub port.
//
// Ports
//   i_clk         clock, all state on rising edge
//   i_rst         synchronous active-high reset, aborts any operation
//   i_in_valid    request valid
//   o_in_ready    request accepted (high only in IDLE)
//   i_a, i_b      packed-BCD operands, 8*NBYTES bits
//   i_cin         decimal carry into digit 0
//   i_sub         subtract request (BCD_SUB_EN only)
//   o_out_valid   result valid (DONE)
//   i_out_ready   consumer takes the result
//   o_s           packed-BCD sum
//   o_cout        decimal carry out of the top digit
//   o_digit_err   some operand nibble was > 9
//   o_busy        state != IDLE
// ---------------------------------------------------------------------------

// One BCD digit position: 4-bit binary add with decimal correction.
module bcd_digit_add (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_c,
    output logic [3:0] o_d,
    output logic       o_c
);
    logic [4:0] w_t;
    logic [4:0] w_adj;

    always_comb begin
        w_t   = {1'b0, i_a} + {1'b0, i_b} + {4'd0, i_c};
        w_adj = w_t + 5'd6;
        // Non-BCD inputs still take this path; the +6 result is simply
        // truncated to 4 bits.
        if (w_t > 5'd9) begin
            o_d = w_adj[3:0];
            o_c = 1'b1;
        end else begin
            o_d = w_t[3:0];
            o_c = 1'b0;
        end
    end
endmodule

module bcd_serial_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [8*NBYTES-1:0]   i_a,
    input  logic [8*NBYTES-1:0]   i_b,
    input  logic                  i_cin,
`ifdef BCD_SUB_EN
    input  logic                  i_sub,
`endif
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [8*NBYTES-1:0]   o_s,
    output logic                  o_cout,
    output logic                  o_digit_err,
    output logic                  o_busy
);
    localparam int W      = 8 * NBYTES;
    localparam int NDIG   = 2 * NBYTES;
    localparam int LANES  = 2;                       // digits per adder stage
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
    } req_t;

    logic [1:0]    r_state;
    logic [W-1:0]  r_a;        // shifted right one byte per ADD cycle
    logic [W-1:0]  r_b;
    logic          r_carry;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  r_s;
    logic          r_cout;
    logic          r_derr;

    logic          w_sub;
    logic          w_derr;
    req_t          w_req;

`ifdef BCD_SUB_EN
    assign w_sub = i_sub;
`else
    assign w_sub = 1'b0;
`endif

    // Accept-side preprocessing: nibble validity on the original operands,
    // and the optional nine's complement of b for subtraction.
    always_comb begin
        w_derr   = 1'b0;
        w_req.a  = i_a;
        w_req.b  = i_b;
        w_req.c  = w_sub ? 1'b1 : i_cin;
        for (int d = 0; d < NDIG; d++) begin
            if (i_a[4*d +: 4] > 4'd9 || i_b[4*d +: 4] > 4'd9)
                w_derr = 1'b1;
            if (w_sub)
                w_req.b[4*d +: 4] = 4'd9 - i_b[4*d +: 4];
        end
    end

    // Two digit lanes chained through the carry: lane 0 = low digit.
    logic [LANES-1:0][3:0] w_da;
    logic [LANES-1:0][3:0] w_db;
    logic [LANES-1:0][3:0] w_dd;
    logic [LANES:0]        w_c;
    logic [7:0]            w_byte;

    assign w_c[0] = r_carry;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign w_da[g] = r_a[4*g +: 4];
            assign w_db[g] = r_b[4*g +: 4];
            bcd_digit_add u_dig (
                .i_a (w_da[g]),
                .i_b (w_db[g]),
                .i_c (w_c[g]),
                .o_d (w_dd[g]),
                .o_c (w_c[g+1])
            );
        end
    endgenerate

    assign w_byte = w_dd;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_derr  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= w_req.a;
                        r_b     <= w_req.b;
                        r_carry <= w_req.c;
                        r_idx   <= '0;
                        r_derr  <= w_derr;
                        r_state <= S_ADD;
                    end
                end
                S_ADD: begin
                    // Constant-index byte write keeps the select in range
                    // for every NBYTES.
                    for (int k = 0; k < NBYTES; k++)
                        if (r_idx == IW'(k))
                            r_s[8*k +: 8] <= w_byte;
                    r_a     <= r_a >> 8;
                    r_b     <= r_b >> 8;
                    r_carry <= w_c[LANES];
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_c[LANES];
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                S_DONE: begin
                    if (i_out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_out_valid = (r_state == S_DONE);
    assign o_s         = r_s;
    assign o_cout      = r_cout;
    assign o_digit_err = r_derr;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: directed vectors with literal
// expectations, randomized operations against a digit-level model, and a
// decimal-arithmetic cross-check of that model. A second instance with
// NBYTES=1 covers the single-byte case.
module tb_bcd_serial_add_ctrl;
    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, in_valid, in_ready, cin, sub, out_valid, out_ready;
    logic         cout, derr, busy;
    logic [W-1:0] a, b, s;

    logic         u1_in_valid, u1_in_ready, u1_cin, u1_out_valid, u1_out_ready;
    logic         u1_cout, u1_derr, u1_busy;
    logic [7:0]   u1_a, u1_b, u1_s;

    bcd_serial_add_ctrl #(.NBYTES(NB)) dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_a(a), .i_b(b), .i_cin(cin),
`ifdef BCD_SUB_EN
        .i_sub(sub),
`endif
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_s(s),
        .o_cout(cout), .o_digit_err(derr), .o_busy(busy)
    );

    bcd_serial_add_ctrl #(.NBYTES(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(u1_in_valid), .o_in_ready(u1_in_ready),
        .i_a(u1_a), .i_b(u1_b), .i_cin(u1_cin),
`ifdef BCD_SUB_EN
        .i_sub(1'b0),
`endif
        .o_out_valid(u1_out_valid), .i_out_ready(u1_out_ready), .o_s(u1_s),
        .o_cout(u1_cout), .o_digit_err(u1_derr), .o_busy(u1_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Digit-serial rule applied to whole numbers held in 64-bit variables.
    function automatic void model(input int nb, input logic [63:0] av, input logic [63:0] bv,
                                  input bit ci, input bit sb,
                                  output logic [63:0] so, output bit co, output bit de);
        int da, db, t, c, d;
        so = '0; de = 0;
        c  = sb ? 1 : int'(ci);
        for (int i = 0; i < 2*nb; i++) begin
            da = int'((av >> (4*i)) & 64'hF);
            db = int'((bv >> (4*i)) & 64'hF);
            if (da > 9 || db > 9) de = 1;
            if (sb) db = (9 - db) & 15;
            t = da + db + c;
            if (t > 9) begin d = (t + 6) & 15; c = 1; end
            else       begin d = t;            c = 0; end
            so = so | (64'(d) << (4*i));
        end
        co = (c != 0);
    endfunction

    function automatic longint dec(input logic [63:0] v, input int nb);
        longint r = 0;
        for (int i = 2*nb - 1; i >= 0; i--) r = r * 10 + longint'((v >> (4*i)) & 64'hF);
        return r;
    endfunction

    function automatic logic [63:0] rand_bcd(input int nb);
        logic [63:0] r = '0;
        for (int i = 0; i < 2*nb; i++) r = r | (64'($urandom_range(0, 9)) << (4*i));
        return r;
    endfunction

    typedef struct { logic [W-1:0] s; bit c; bit de; } exp_t;
    exp_t q[$];

    // Compare process: every cycle the result is offered it must match the
    // oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy_not_ready", 64'(busy), 64'(!in_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    chk("s",         64'(s),    64'(q[0].s));
                    chk("cout",      64'(cout), 64'(q[0].c));
                    chk("digit_err", 64'(derr), 64'(q[0].de));
                end
            end
        end
    end

    always @(posedge clk)
        if (!rst && out_valid && out_ready && q.size() > 0) void'(q.pop_front());

    // One operation on the NBYTES=2 instance. hold<0: out_ready high the
    // whole time; otherwise hold DONE that many extra cycles.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit ci,
                         input bit sb, input int hold, input bit lit,
                         input logic [W-1:0] ls, input bit lc, input bit lde);
        logic [63:0] ms; bit mc, mde; int k; logic [W-1:0] sv;
        exp_t e;
        model(NB, 64'(av), 64'(bv), ci, sb, ms, mc, mde);
        e.s = ms[W-1:0]; e.c = mc; e.de = mde;
        out_ready = (hold < 0);
        in_valid = 1'b1; a = av; b = bv; cin = ci; sub = sb;
        @(negedge clk);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        q.push_back(e);
        @(posedge clk); #1;
        // Keep requesting with junk operands: must be ignored while busy.
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (out_valid) break;
            k++;
        end
        chk("latency", 64'(k), 64'(NB));
        sv = s;
        if (lit) begin
            chk("lit_s", 64'(s), 64'(ls));
            chk("lit_cout", 64'(cout), 64'(lc));
            chk("lit_derr", 64'(derr), 64'(lde));
        end
        if (hold >= 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_s", 64'(s), 64'(sv));
                chk("hold_in_ready", 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0; sub = 1'b0;
        @(negedge clk);
        chk("post_valid", 64'(out_valid), 64'd0);
        chk("post_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_op1(input logic [7:0] av, input logic [7:0] bv, input bit ci);
        logic [63:0] ms; bit mc, mde; int k;
        model(1, 64'(av), 64'(bv), ci, 1'b0, ms, mc, mde);
        u1_in_valid = 1'b1; u1_a = av; u1_b = bv; u1_cin = ci;
        @(posedge clk); #1;
        u1_in_valid = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk);
            if (u1_out_valid) break;
            k++;
        end
        chk("u1_latency", 64'(k), 64'd1);
        chk("u1_s", 64'(u1_s), ms & 64'hFF);
        chk("u1_cout", 64'(u1_cout), 64'(mc));
        chk("u1_derr", 64'(u1_derr), 64'(mde));
        u1_out_ready = 1'b1;
        @(posedge clk); #1;
        u1_out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ms; bit mc, mde;
        logic [W-1:0] ra, rb; bit rc, rs; int rh; longint sum;
        rst = 1'b1; in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0; sub = 0;
        u1_in_valid = 0; u1_out_ready = 0; u1_a = '0; u1_b = '0; u1_cin = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_s", 64'(s), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_derr", 64'(derr), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Literal pins on the model itself.
        model(NB, 64'h1234, 64'h5678, 1'b0, 1'b0, ms, mc, mde);
        chk("model_6912", ms, 64'h6912);
        model(1, 64'h58, 64'h47, 1'b0, 1'b0, ms, mc, mde);
        chk("model_58_47", {ms[62:0], mc}, {64'h05, 1'b1} & 64'h1FF);

        // Directed vectors.
        do_op(16'h1234, 16'h5678, 0, 0, 0,  1, 16'h6912, 0, 0);
        do_op(16'h9999, 16'h0001, 0, 0, -1, 1, 16'h0000, 1, 0);
        do_op(16'h0000, 16'h0000, 1, 0, 0,  1, 16'h0001, 0, 0);
        do_op(16'h1111, 16'h2222, 0, 0, 5,  1, 16'h3333, 0, 0);
        do_op(16'h1A00, 16'h0000, 0, 0, 1,  1, 16'h2000, 0, 1);

        // Abort on the first ADD cycle.
        in_valid = 1'b1; a = 16'h4545; b = 16'h5555; cin = 0;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_s", 64'(s), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        @(posedge clk); #1;
        do_op(16'h0011, 16'h0022, 0, 0, 0, 1, 16'h0033, 0, 0);

`ifdef BCD_SUB_EN
        do_op(16'h0100, 16'h0001, 0, 1, 0, 1, 16'h0099, 1, 0);
        do_op(16'h0001, 16'h0002, 0, 1, 0, 1, 16'h9999, 0, 0);
`endif

        // Randomized operations, model cross-checked against decimal math.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                ra = W'($urandom); rb = W'($urandom);
            end else begin
                ra = W'(rand_bcd(NB)); rb = W'(rand_bcd(NB));
            end
            rc = 1'($urandom);
`ifdef BCD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            rh = int'($urandom_range(0, 4)) - 1;
            model(NB, 64'(ra), 64'(rb), rc, rs, ms, mc, mde);
            if (!mde) begin
                if (rs) sum = dec(64'(ra), NB) - dec(64'(rb), NB) + 10000;
                else    sum = dec(64'(ra), NB) + dec(64'(rb), NB) + longint'(rc);
                chk("model_dec_s", 64'(dec(ms, NB)), 64'(sum % 10000));
                chk("model_dec_c", 64'(mc), 64'(sum >= 10000));
            end
            do_op(ra, rb, rc, rs, rh, 0, '0, 0, 0);
        end

        // Single-byte instance.
        do_op1(8'h58, 8'h47, 0);
        do_op1(8'h99, 8'h00, 1);
        for (int n = 0; n < 10; n++) do_op1(8'(rand_bcd(1)), 8'(rand_bcd(1)), 1'($urandom));

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
